// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle RISC-V control path: FSM states, opcodes
// and the mux select / ALUOp codes that the datapath and alu_control agree on.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11,
    S_RSVD     = 4'd12
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_MEMDATA   = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/multicycle_control_opcode_decode.sv
// Combinational opcode map: the state DECODE moves to, plus a load flag that
// MEMADR uses to choose between the read and write paths.
module multicycle_control_opcode_decode
  import multicycle_control_pkg::*;
(
  input  logic [6:0] opcode,
  output state_e     decode_next,
  output logic       is_load
);

  always_comb begin
    decode_next = S_TRAP;
    is_load     = (opcode == OP_LOAD);
    case (opcode)
      OP_LOAD, OP_STORE: decode_next = S_MEMADR;
      OP_RTYPE:          decode_next = S_EXECR;
      OP_ITYPE:          decode_next = S_EXECI;
      OP_BRANCH:         decode_next = S_BEQ;
      OP_JAL:            decode_next = S_JAL;
      default:           decode_next = S_TRAP;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle RISC-V datapath: sequences each instruction,
// drives selects/enables, stalls on mem_ready and counts retired instructions.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             adr_src,
  output logic             ir_write,
  output logic             mem_write,
  output logic             reg_write,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             illegal_instr,
  output logic [CNT_W-1:0] instr_count,
  output logic [3:0]       state_dbg
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  state_e           decode_next;
  logic             is_load;
  logic             retire;

  multicycle_control_opcode_decode u_opcode_decode (
    .opcode      (opcode),
    .decode_next (decode_next),
    .is_load     (is_load)
  );

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE:   state_d = decode_next;
      S_MEMADR:   state_d = is_load ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:    begin state_d = S_FETCH; retire = 1'b1; end
      S_MEMWRITE: if (mem_ready) begin state_d = S_FETCH; retire = 1'b1; end
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    begin state_d = S_FETCH; retire = 1'b1; end
      S_BEQ:      begin state_d = S_FETCH; retire = 1'b1; end
      S_JAL:      state_d = S_ALUWB;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_FETCH;
    endcase
    count_d = retire ? count_q + 1'b1 : count_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Moore decode of state_q; mem_ready and zero are the only direct input terms,
  // and reset masks every write enable so nothing is committed during reset.
  always_comb begin
    pc_write      = 1'b0;
    adr_src       = 1'b0;
    ir_write      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    result_src    = RES_ALUOUT;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_RS2;
    alu_op        = ALUOP_ADD;
    illegal_instr = 1'b0;
    case (state_q)
      S_FETCH: begin
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMREAD:  adr_src = 1'b1;
      S_MEMWB: begin
        result_src = RES_MEMDATA;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALUOP_FUNCT;
      end
      S_EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB:    reg_write = 1'b1;
      S_BEQ: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALUOP_SUB;
        pc_write  = zero;
      end
      S_JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_write  = 1'b1;
      end
      S_TRAP:     illegal_instr = 1'b1;
      default: ;
    endcase
    if (reset) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
    end
  end

  assign instr_count = count_q;
  assign state_dbg   = state_q;

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multicycle RISC-V datapath.
- Sequences fetch, decode, execute, memory and writeback for lw, sw, R-type, I-type ALU, beq and jal.
- Drives the mux selects and write enables, and produces the 2-bit ALUOp consumed by alu_control.
- Stalls on a memory ready handshake and counts retired instructions.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; one clock, reset sampled on the rising edge of clk.
- opcode  in  7  instr[6:0] from the instruction register.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_write  out  1  PC register enable.
- adr_src  out  1  memory address select: 0 = PC, 1 = result bus.
- ir_write  out  1  instruction/OldPC register enable.
- mem_write  out  1  data memory write strobe.
- reg_write  out  1  register file write enable.
- result_src  out  2  result select: 00 = ALUOut, 01 = memory data, 10 = ALU result.
- alu_src_a  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1 register.
- alu_src_b  out  2  ALU B select: 00 = rs2 register, 01 = immediate, 10 = constant 4.
- alu_op  out  2  to alu_control: 00 = add, 01 = branch/sub, 10 = decode funct fields.
- illegal_instr  out  1  high while in TRAP.
- instr_count  out  CNT_W  instructions retired since reset.
- state_dbg  out  4  current state encoding, for debug.

Behaviour:
- Moore FSM with 13 states; outputs decode from the state register. The only Mealy terms are the mem_ready gating and pc_write in BEQ.
- Any output not listed for a state is 0.
- Reset: the state loads FETCH and instr_count loads 0 on the edge.
  - While reset is high, pc_write, ir_write, mem_write and reg_write are forced 0.
  - Reset mid-instruction abandons the instruction; it is not counted.
- State encodings (4 bits): FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BEQ 9, JAL 10, TRAP 11.
  - Encoding 12 is reserved; any unused encoding transitions to FETCH.
- FETCH: adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10.
  - ir_write and pc_write equal mem_ready.
  - Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE: alu_src_a=01, alu_src_b=01, alu_op=00 (branch target into ALUOut). Next state by opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - any other opcode -> TRAP
- MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00. Next is MEMREAD if opcode=0000011, else MEMWRITE.
- MEMREAD: adr_src=1, result_src=00. Wait for mem_ready, then MEMWB.
- MEMWB: result_src=01, reg_write=1. Next FETCH.
- MEMWRITE: adr_src=1, result_src=00, mem_write=1.
  - mem_write is held high until mem_ready, then FETCH.
- EXECR: alu_src_a=10, alu_src_b=00, alu_op=10. Next ALUWB.
- EXECI: alu_src_a=10, alu_src_b=01, alu_op=10. Next ALUWB.
- ALUWB: result_src=00, reg_write=1. Next FETCH.
- BEQ: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, pc_write=zero. Next FETCH.
- JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_write=1 (PC loads the target). Next ALUWB (rd <- PC+4).
- TRAP: illegal_instr=1, all enables 0. Held until reset; no count.
- instr_count increments by 1 on each transition into FETCH from MEMWB, MEMWRITE, ALUWB or BEQ.
  - Wraps modulo 2^CNT_W without saturation.
- Cycle counts with zero wait states:
  - lw 5, sw 4, R/I-type 4, beq 3, jal 4.
  - Each cycle with mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- opcode is sampled only in DECODE and MEMADR. The IR is stable after FETCH, so no other state depends on it.

Decomposition:
- Shared header multicycle_defs.vh holds:
  - state encodings
  - the six opcode constants
  - select encodings for result_src, alu_src_a, alu_src_b and alu_op (alu_op values shared with alu_control)
- One natural sub-module: opcode_decode, a combinational map from opcode to DECODE's next state plus an is_load flag, reused in MEMADR.

Test Plan:
- Reset high for 2 cycles -> state_dbg=0, instr_count=0, all write enables 0 even though the FSM is in FETCH; release -> ir_write=1 on the first cycle with mem_ready=1.
- opcode=0110011, mem_ready=1 -> state sequence 0,1,6,8,0; alu_op=10 in EXECR; reg_write=1 only in ALUWB; instr_count=1.
- opcode=0000011, mem_ready low for 2 cycles in MEMREAD -> sequence 0,1,2,3,3,3,4,0 (7 cycles); result_src=01 and reg_write=1 in MEMWB.
- opcode=1100011, zero=1 then zero=0 -> pc_write=1 in BEQ for the first and 0 for the second; alu_op=01; instr_count +1 each.
- opcode=0100011, mem_ready=0 for 1 cycle in MEMWRITE -> mem_write high for 2 consecutive cycles, then FETCH.
- opcode=1111111 -> TRAP (state_dbg=11), illegal_instr=1 held 10 cycles, instr_count unchanged; reset -> FETCH, illegal_instr=0.
